// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundle of one requester's signals toward the DMem arbiter. One instance is
//   used per master (openMSP430 data bus, second on-chip requester).
//
//   Signals
//     req     requester -> arbiter  access request, held until granted
//     we      requester -> arbiter  byte write enables, active high (00 = read)
//     addr    requester -> arbiter  word address
//     wdata   requester -> arbiter  write data
//     gnt     arbiter -> requester  combinational grant, access issues this cycle
//     rvalid  arbiter -> requester  read data valid, one cycle after a granted read
//     rdata   arbiter -> requester  read data (RAM output, valid with rvalid)
//
//   Modports
//     master  used by the requester
//     slave   used by the arbiter
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_MSB = 9
);
    logic                req;
    logic [1:0]          we;
    logic [ADDR_MSB:0]   addr;
    logic [15:0]         wdata;
    logic                gnt;
    logic                rvalid;
    logic [15:0]         rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-ported data memory between two requesters. Master 0
//   (CPU data bus) has fixed priority; master 1 is guaranteed forward progress
//   by a starvation counter: after STARVE_LIMIT consecutive denied cycles it
//   wins exactly one access. Grants are combinational (zero latency), the RAM
//   captures the access at the end of the grant cycle and read data returns
//   one cycle later, tagged by rvalid toward the master that issued the read.
//
//   Parameters
//     ADDR_MSB      MSB of the word address
//     STARVE_LIMIT  denied cycles before master 1 takes priority (1..15)
//
//   Ports
//     ram_clk       clock shared with the DMem RAM
//     ram_rstn      synchronous reset, active low
//     m0, m1        requester buses (slave side)
//     ram_addr      address to DMem
//     ram_cen       chip enable, active low
//     ram_wen       byte write enables, active low
//     ram_din       write data to DMem
//     ram_dout      read data from DMem (one-cycle latency)
//     conflict_cnt  saturating count of cycles in which both masters requested
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_MSB     = 9,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                ram_clk,
    input  logic                ram_rstn,
    dmem_arbiter_if.slave       m0,
    dmem_arbiter_if.slave       m1,
    output logic [ADDR_MSB:0]   ram_addr,
    output logic                ram_cen,
    output logic [1:0]          ram_wen,
    output logic [15:0]         ram_din,
    input  logic [15:0]         ram_dout,
    output logic [15:0]         conflict_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Which master owns the RAM port in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    // Per-master views of the request buses, indexed 0/1.
    logic [1:0]          req;
    logic [1:0]          we_arr    [2];
    logic [ADDR_MSB:0]   addr_arr  [2];
    logic [15:0]         wdata_arr [2];

    owner_t              owner;
    logic [1:0]          gnt;
    logic                starve;

    logic [3:0]          wait_cnt_reg;
    logic [3:0]          wait_cnt_next;
    logic [1:0]          rd_reg;
    logic [1:0]          rd_next;
    logic [15:0]         conflict_cnt_reg;
    logic [15:0]         conflict_cnt_next;

    assign req[0]       = m0.req;
    assign req[1]       = m1.req;
    assign we_arr[0]    = m0.we;
    assign we_arr[1]    = m1.we;
    assign addr_arr[0]  = m0.addr;
    assign addr_arr[1]  = m1.addr;
    assign wdata_arr[0] = m0.wdata;
    assign wdata_arr[1] = m1.wdata;

    assign starve = (wait_cnt_reg == LIMIT);

    // Grant selection: a starved master 1 overrides master 0 for one cycle;
    // the grant itself clears the counter so the override never repeats
    // back to back.
    always_comb begin
        owner = OWN_NONE;
        if (ram_rstn) begin
            if (req[1] && starve) begin
                owner = OWN_M1;
            end else if (req[0]) begin
                owner = OWN_M0;
            end else if (req[1]) begin
                owner = OWN_M1;
            end
        end
    end

    assign gnt[0] = (owner == OWN_M0);
    assign gnt[1] = (owner == OWN_M1);

    // RAM port mux. With no owner the address/data simply follow master 0 so
    // the idle mux path is the short one; they are don't-care while cen is high.
    always_comb begin
        ram_addr = addr_arr[0];
        ram_din  = wdata_arr[0];
        ram_cen  = 1'b1;
        ram_wen  = 2'b11;
        case (owner)
            OWN_M0: begin
                ram_cen = 1'b0;
                ram_wen = ~we_arr[0];
            end
            OWN_M1: begin
                ram_addr = addr_arr[1];
                ram_din  = wdata_arr[1];
                ram_cen  = 1'b0;
                ram_wen  = ~we_arr[1];
            end
            default: begin
                ram_cen  = 1'b1;
                ram_wen  = 2'b11;
            end
        endcase
    end

    // Starvation counter: counts consecutive denied cycles of master 1,
    // saturating at the limit; any grant or dropped request starts over.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!req[1] || gnt[1]) begin
            wait_cnt_next = 4'd0;
        end else if (wait_cnt_reg != LIMIT) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
        end
    end

    // A read is pending for the master that was granted with no byte enables.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            assign rd_next[gi] = gnt[gi] & (we_arr[gi] == 2'b00);
        end
    endgenerate

    always_comb begin
        conflict_cnt_next = conflict_cnt_reg;
        if (req[0] && req[1] && (conflict_cnt_reg != 16'hFFFF)) begin
            conflict_cnt_next = conflict_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge ram_clk) begin
        if (!ram_rstn) begin
            wait_cnt_reg     <= 4'd0;
            rd_reg           <= 2'b00;
            conflict_cnt_reg <= 16'd0;
        end else begin
            wait_cnt_reg     <= wait_cnt_next;
            rd_reg           <= rd_next;
            conflict_cnt_reg <= conflict_cnt_next;
        end
    end

    assign m0.gnt    = gnt[0];
    assign m1.gnt    = gnt[1];
    // Gating with reset drops a read that was granted just before reset
    // asserted: its rvalid would otherwise appear in the first reset cycle.
    assign m0.rvalid = rd_reg[0] & ram_rstn;
    assign m1.rvalid = rd_reg[1] & ram_rstn;
    assign m0.rdata  = ram_dout;
    assign m1.rdata  = ram_dout;

    assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter: table of single-cycle grant vectors,
//   directed multi-cycle sequences, a random phase and a saturation run, all
//   compared against a behavioural model (shadow memory, read-return queue,
//   wait-cycle count) evaluated every cycle.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int ADDR_MSB     = 9;
    localparam int STARVE_LIMIT = 3;
    localparam int DEPTH        = 1 << (ADDR_MSB + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rstn;
    logic [ADDR_MSB:0]   ram_addr;
    logic                ram_cen;
    logic [1:0]          ram_wen;
    logic [15:0]         ram_din;
    logic [15:0]         ram_dout;
    logic [15:0]         conflict_cnt;

    dmem_arbiter_if #(.ADDR_MSB(ADDR_MSB)) m0_bus ();
    dmem_arbiter_if #(.ADDR_MSB(ADDR_MSB)) m1_bus ();

    dmem_arbiter #(
        .ADDR_MSB     (ADDR_MSB),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .ram_clk      (clk),
        .ram_rstn     (rstn),
        .m0           (m0_bus),
        .m1           (m1_bus),
        .ram_addr     (ram_addr),
        .ram_cen      (ram_cen),
        .ram_wen      (ram_wen),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .conflict_cnt (conflict_cnt)
    );

    // Single-port RAM with one-cycle registered read and byte writes.
    logic [15:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (!ram_cen) begin
            ram_dout <= ram_mem[ram_addr];
            if (!ram_wen[0]) ram_mem[ram_addr][7:0]  <= ram_din[7:0];
            if (!ram_wen[1]) ram_mem[ram_addr][15:8] <= ram_din[15:8];
        end
    end

    // Behavioural model state.
    logic [15:0] shadow [DEPTH];
    int          m_wait;          // consecutive cycles master 1 has been denied
    int          m_conf;
    logic        m_rv0, m_rv1;
    logic [15:0] m_rd0, m_rd1;
    logic        m_g0, m_g1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output with the model for the current cycle, then
    // advance the model across the coming clock edge.
    task automatic check_and_model();
        logic [1:0] exp_wen;
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (rstn) begin
            if (m1_bus.req && m_wait >= STARVE_LIMIT) m_g1 = 1'b1;
            else if (m0_bus.req)                      m_g0 = 1'b1;
            else if (m1_bus.req)                      m_g1 = 1'b1;
        end
        exp_wen = m_g0 ? ~m0_bus.we : (m_g1 ? ~m1_bus.we : 2'b11);
        chk("m0_gnt", 32'(m0_bus.gnt), 32'(m_g0));
        chk("m1_gnt", 32'(m1_bus.gnt), 32'(m_g1));
        chk("ram_cen", 32'(ram_cen), 32'(!(m_g0 || m_g1)));
        chk("ram_wen", 32'(ram_wen), 32'(exp_wen));
        if (m_g0) begin
            chk("ram_addr_m0", 32'(ram_addr), 32'(m0_bus.addr));
            chk("ram_din_m0", 32'(ram_din), 32'(m0_bus.wdata));
        end
        if (m_g1) begin
            chk("ram_addr_m1", 32'(ram_addr), 32'(m1_bus.addr));
            chk("ram_din_m1", 32'(ram_din), 32'(m1_bus.wdata));
        end
        chk("m0_rvalid", 32'(m0_bus.rvalid), 32'(m_rv0 && rstn));
        chk("m1_rvalid", 32'(m1_bus.rvalid), 32'(m_rv1 && rstn));
        if (m_rv0 && rstn) chk("m0_rdata", 32'(m0_bus.rdata), 32'(m_rd0));
        if (m_rv1 && rstn) chk("m1_rdata", 32'(m1_bus.rdata), 32'(m_rd1));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));

        if (!rstn) begin
            m_wait = 0;
            m_conf = 0;
            m_rv0  = 1'b0;
            m_rv1  = 1'b0;
        end else begin
            if (m1_bus.req && !m_g1) m_wait = (m_wait < STARVE_LIMIT) ? m_wait + 1 : STARVE_LIMIT;
            else                     m_wait = 0;
            m_rv0 = m_g0 && (m0_bus.we == 2'b00);
            m_rv1 = m_g1 && (m1_bus.we == 2'b00);
            m_rd0 = shadow[m0_bus.addr];
            m_rd1 = shadow[m1_bus.addr];
            if (m_g0) begin
                if (m0_bus.we[0]) shadow[m0_bus.addr][7:0]  = m0_bus.wdata[7:0];
                if (m0_bus.we[1]) shadow[m0_bus.addr][15:8] = m0_bus.wdata[15:8];
            end
            if (m_g1) begin
                if (m1_bus.we[0]) shadow[m1_bus.addr][7:0]  = m1_bus.wdata[7:0];
                if (m1_bus.we[1]) shadow[m1_bus.addr][15:8] = m1_bus.wdata[15:8];
            end
            if (m0_bus.req && m1_bus.req && m_conf < 65535) m_conf = m_conf + 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_and_model();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rs,
                         input logic r0, input logic [1:0] w0, input logic [ADDR_MSB:0] a0, input logic [15:0] d0,
                         input logic r1, input logic [1:0] w1, input logic [ADDR_MSB:0] a1, input logic [15:0] d1);
        rstn         = rs;
        m0_bus.req   = r0;
        m0_bus.we    = w0;
        m0_bus.addr  = a0;
        m0_bus.wdata = d0;
        m1_bus.req   = r1;
        m1_bus.we    = w1;
        m1_bus.addr  = a1;
        m1_bus.wdata = d1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 2'b00, '0, 16'h0, 1'b0, 2'b00, '0, 16'h0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 2'b00, '0, 16'h0, 1'b0, 2'b00, '0, 16'h0);
        tick();
        adv();
    endtask

    typedef struct {
        logic              rs;
        logic              r0;
        logic [1:0]        w0;
        logic [ADDR_MSB:0] a0;
        logic              r1;
        logic [1:0]        w1;
        logic [ADDR_MSB:0] a1;
        logic              eg0;
        logic              eg1;
        logic              ecen;
        logic [1:0]        ewen;
        logic [ADDR_MSB:0] eaddr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic              p0, p1;
        logic [1:0]        w0, w1;
        logic [ADDR_MSB:0] a0, a1;
        logic [15:0]       d0, d1;

        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = 16'h0;
            shadow[i]  = 16'h0;
        end
        ram_dout = 16'h0;
        m_wait = 0; m_conf = 0; m_rv0 = 1'b0; m_rv1 = 1'b0;
        m_rd0 = 16'h0; m_rd1 = 16'h0;

        //         rs  r0  w0     a0      r1  w1     a1      g0  g1  cen wen    addr
        vecs[0] = '{1'b0, 1'b1, 2'b11, 10'd10, 1'b1, 2'b11, 10'd20, 1'b0, 1'b0, 1'b1, 2'b11, 10'd10};
        vecs[1] = '{1'b1, 1'b1, 2'b11, 10'd11, 1'b0, 2'b00, 10'd21, 1'b1, 1'b0, 1'b0, 2'b00, 10'd11};
        vecs[2] = '{1'b1, 1'b1, 2'b00, 10'd12, 1'b0, 2'b11, 10'd22, 1'b1, 1'b0, 1'b0, 2'b11, 10'd12};
        vecs[3] = '{1'b1, 1'b0, 2'b11, 10'd13, 1'b1, 2'b10, 10'd23, 1'b0, 1'b1, 1'b0, 2'b01, 10'd23};
        vecs[4] = '{1'b1, 1'b1, 2'b01, 10'd14, 1'b1, 2'b10, 10'd24, 1'b1, 1'b0, 1'b0, 2'b10, 10'd14};
        vecs[5] = '{1'b1, 1'b0, 2'b11, 10'd15, 1'b0, 2'b11, 10'd25, 1'b0, 1'b0, 1'b1, 2'b11, 10'd15};
        vecs[6] = '{1'b1, 1'b0, 2'b01, 10'd16, 1'b1, 2'b00, 10'd26, 1'b0, 1'b1, 1'b0, 2'b11, 10'd26};
        vecs[7] = '{1'b0, 1'b1, 2'b00, 10'd17, 1'b0, 2'b00, 10'd27, 1'b0, 1'b0, 1'b1, 2'b11, 10'd17};

        // Establish a known register state before the first comparison.
        drive(1'b0, 1'b1, 2'b11, '0, 16'h0, 1'b1, 2'b11, '0, 16'h0);
        adv();

        // Reset held with both masters requesting.
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_conflict", 32'(conflict_cnt), 32'h0);
            chk("rst_rvalid", 32'({m0_bus.rvalid, m1_bus.rvalid}), 32'h0);
            adv();
        end
        $display("reset: gnt=%b%b cen=%b wen=%b cnt=%0d", m1_bus.gnt, m0_bus.gnt, ram_cen, ram_wen, conflict_cnt);

        // Single-cycle grant/mux vectors, each from a cleared wait state.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].rs, vecs[i].r0, vecs[i].w0, vecs[i].a0, 16'h1000 + 16'(i),
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, 16'h2000 + 16'(i));
            tick();
            chk("vec_g0", 32'(m0_bus.gnt), 32'(vecs[i].eg0));
            chk("vec_g1", 32'(m1_bus.gnt), 32'(vecs[i].eg1));
            chk("vec_cen", 32'(ram_cen), 32'(vecs[i].ecen));
            chk("vec_wen", 32'(ram_wen), 32'(vecs[i].ewen));
            chk("vec_addr", 32'(ram_addr), 32'(vecs[i].eaddr));
            $display("vec %0d: gnt=%b%b cen=%b wen=%b addr=%0d", i, m1_bus.gnt, m0_bus.gnt, ram_cen, ram_wen, ram_addr);
            adv();
            idle();
            tick();
            adv();
        end

        // Master-0 write then read of addr 5.
        drive(1'b1, 1'b1, 2'b11, 10'd5, 16'hA5C3, 1'b0, 2'b00, '0, 16'h0);
        tick(); chk("wr0_gnt", 32'(m0_bus.gnt), 32'h1); adv();
        drive(1'b1, 1'b1, 2'b00, 10'd5, 16'h0, 1'b0, 2'b00, '0, 16'h0);
        tick(); chk("rd0_gnt", 32'(m0_bus.gnt), 32'h1); chk("rd0_m1rv", 32'(m1_bus.rvalid), 32'h0); adv();
        idle();
        tick();
        chk("rd0_rvalid", 32'(m0_bus.rvalid), 32'h1);
        chk("rd0_rdata", 32'(m0_bus.rdata), 32'hA5C3);
        chk("rd0_m1rv2", 32'(m1_bus.rvalid), 32'h0);
        $display("m0 read addr 5: rvalid=%b data=%h", m0_bus.rvalid, m0_bus.rdata);
        adv();

        // Master-1 byte write.
        drive(1'b1, 1'b0, 2'b00, '0, 16'h0, 1'b1, 2'b11, 10'd7, 16'h1234);
        tick(); adv();
        drive(1'b1, 1'b0, 2'b00, '0, 16'h0, 1'b1, 2'b10, 10'd7, 16'hFF00);
        tick(); adv();
        drive(1'b1, 1'b0, 2'b00, '0, 16'h0, 1'b1, 2'b00, 10'd7, 16'h0);
        tick(); adv();
        idle();
        tick();
        chk("byte_rvalid", 32'(m1_bus.rvalid), 32'h1);
        chk("byte_rdata", 32'(m1_bus.rdata), 32'hFF34);
        $display("m1 read addr 7: rvalid=%b data=%h", m1_bus.rvalid, m1_bus.rdata);
        adv();

        // Starvation: m0 requests continuously, m1 from cycle 0 until granted.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b1, 2'b00, 10'd0, 16'h0, (c <= 3), 2'b00, 10'd3, 16'h0);
            tick();
            chk("starve_g1", 32'(m1_bus.gnt), 32'(c == 3));
            chk("starve_g0", 32'(m0_bus.gnt), 32'(c != 3));
            if (c >= 4) chk("starve_cnt", 32'(conflict_cnt), 32'd4);
            $display("starve cycle %0d: gnt=%b%b cnt=%0d", c, m1_bus.gnt, m0_bus.gnt, conflict_cnt);
            adv();
        end

        // Interleaved reads: m1 then m0 on consecutive cycles.
        drive(1'b1, 1'b1, 2'b11, 10'd1, 16'h0001, 1'b0, 2'b00, '0, 16'h0);
        tick(); adv();
        drive(1'b1, 1'b1, 2'b11, 10'd2, 16'h0002, 1'b0, 2'b00, '0, 16'h0);
        tick(); adv();
        drive(1'b1, 1'b0, 2'b00, '0, 16'h0, 1'b1, 2'b00, 10'd1, 16'h0);
        tick(); chk("il_g1", 32'(m1_bus.gnt), 32'h1); adv();
        drive(1'b1, 1'b1, 2'b00, 10'd2, 16'h0, 1'b0, 2'b00, '0, 16'h0);
        tick();
        chk("il_m1rv", 32'(m1_bus.rvalid), 32'h1);
        chk("il_m1data", 32'(m1_bus.rdata), 32'h0001);
        chk("il_m0rv_early", 32'(m0_bus.rvalid), 32'h0);
        adv();
        idle();
        tick();
        chk("il_m0rv", 32'(m0_bus.rvalid), 32'h1);
        chk("il_m0data", 32'(m0_bus.rdata), 32'h0002);
        chk("il_m1rv_late", 32'(m1_bus.rvalid), 32'h0);
        $display("interleaved: m0 data=%h m1 rvalid=%b", m0_bus.rdata, m1_bus.rvalid);
        adv();

        // Read granted, reset asserted in the following cycle.
        drive(1'b1, 1'b1, 2'b00, 10'd5, 16'h0, 1'b0, 2'b00, '0, 16'h0);
        tick(); chk("rr_gnt", 32'(m0_bus.gnt), 32'h1); adv();
        drive(1'b0, 1'b0, 2'b00, '0, 16'h0, 1'b0, 2'b00, '0, 16'h0);
        tick(); chk("rr_rv_a", 32'(m0_bus.rvalid), 32'h0); adv();
        idle();
        tick(); chk("rr_rv_b", 32'(m0_bus.rvalid), 32'h0); adv();
        $display("reset mid-read: m0 rvalid=%b", m0_bus.rvalid);

        // Random traffic honouring the hold-until-granted protocol.
        p0 = 1'b0; p1 = 1'b0;
        w0 = 2'b00; w1 = 2'b00; a0 = '0; a1 = '0; d0 = 16'h0; d1 = 16'h0;
        for (int i = 0; i < 3000; i++) begin
            if (!p0 && ($urandom_range(2) != 0)) begin
                p0 = 1'b1; w0 = 2'($urandom); a0 = 10'($urandom_range(15)); d0 = 16'($urandom);
            end
            if (!p1 && ($urandom_range(2) != 0)) begin
                p1 = 1'b1; w1 = 2'($urandom); a1 = 10'($urandom_range(15)); d1 = 16'($urandom);
            end
            drive(($urandom_range(63) != 0), p0, w0, a0, d0, p1, w1, a1, d1);
            tick();
            if (m_g0) p0 = 1'b0;
            if (m_g1) p1 = 1'b0;
            adv();
        end
        $display("random phase: total=%0d bad=%0d", total, bad);

        // Saturation of the conflict counter.
        do_reset();
        drive(1'b1, 1'b1, 2'b00, 10'd0, 16'h0, 1'b1, 2'b00, 10'd1, 16'h0);
        for (int i = 0; i < 65540; i++) begin
            tick();
            adv();
        end
        tick();
        chk("sat_cnt", 32'(conflict_cnt), 32'hFFFF);
        $display("saturation: conflict_cnt=%h", conflict_cnt);
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
